// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and a req/ack data memory.
// In-order drain, youngest-entry store coalescing, and load forwarding from pending stores.
module store_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CW   = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          memwrite,
   input  logic [AW-1:0] dataadr,
   input  logic [DW-1:0] writedata,
   output logic          stall,
   input  logic [AW-1:0] lookup_adr,
   output logic          fwd_hit,
   output logic [DW-1:0] fwd_data,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   output logic [CW-1:0] count,
   output logic          empty
);

   logic [AW-1:0] addr_q [DEPTH];
   logic [AW-1:0] addr_d [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [DW-1:0] data_d [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic [PW-1:0] youngest;
   logic          full;
   logic          coalesce;
   logic          push;
   logic          pop;

   assign youngest = tail_q - PW'(1);
   assign full     = (count_q == CW'(DEPTH));
   // Head is on the memory bus, so only merge when the youngest entry is not the head.
   assign coalesce = memwrite && (count_q >= CW'(2)) && (dataadr == addr_q[youngest]);
   assign push     = memwrite && !coalesce && !full;
   assign pop      = mem_req && mem_ack;

   assign stall     = memwrite && full && !coalesce;
   assign mem_req   = (count_q != '0);
   assign mem_addr  = addr_q[head_q];
   assign mem_wdata = data_q[head_q];
   assign count     = count_q;
   assign empty     = (count_q == '0);

   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (coalesce) begin
         data_d[youngest] = writedata;
      end
      if (push) begin
         addr_d[tail_q] = dataadr;
         data_d[tail_q] = writedata;
         tail_d         = tail_q + PW'(1);
      end
      if (pop) begin
         head_d = head_q + PW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CW'(1);
      end
   end

   // Scan oldest to youngest so the last match is the youngest one.
   logic [PW-1:0] idx;
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if ((CW'(i) < count_q) && (addr_q[idx] == lookup_adr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[idx];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a queue of pending {addr,data} is the expected buffer
// contents; the front is compared against the memory port each cycle and popped on ack.
module tb_store_buffer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          reset;
   logic          memwrite;
   logic [AW-1:0] dataadr;
   logic [DW-1:0] writedata;
   logic          stall;
   logic [AW-1:0] lookup_adr;
   logic          fwd_hit;
   logic [DW-1:0] fwd_data;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic [CW-1:0] count;
   logic          empty;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [63:0] sb [$];

   store_buffer #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .memwrite   (memwrite),
      .dataadr    (dataadr),
      .writedata  (writedata),
      .stall      (stall),
      .lookup_adr (lookup_adr),
      .fwd_hit    (fwd_hit),
      .fwd_data   (fwd_data),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .count      (count),
      .empty      (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1: drive one cycle, check at negedge, update the model, end at posedge+1.
   task automatic cycle(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                        input logic ack, input logic [31:0] lk);
      int          n;
      logic        coal;
      logic        exp_stall;
      logic        hit;
      logic [31:0] fd;
      memwrite   = we;
      dataadr    = adr;
      writedata  = wd;
      mem_ack    = ack;
      lookup_adr = lk;
      @(negedge clk);
      n         = sb.size();
      coal      = we && (n >= 2) && (sb[n-1][63:32] == adr);
      exp_stall = we && (n == DEPTH) && !coal;
      chk("count", 64'(count), 64'(n));
      chk("mem_req", 64'(mem_req), 64'(n != 0));
      chk("empty", 64'(empty), 64'(n == 0));
      chk("stall", 64'(stall), 64'(exp_stall));
      if (n != 0) begin
         chk("mem_addr", 64'(mem_addr), 64'(sb[0][63:32]));
         chk("mem_wdata", 64'(mem_wdata), 64'(sb[0][31:0]));
      end
      hit = 1'b0;
      fd  = '0;
      for (int i = 0; i < n; i++) begin
         if (sb[i][63:32] == lk) begin
            hit = 1'b1;
            fd  = sb[i][31:0];
         end
      end
      chk("fwd_hit", 64'(fwd_hit), 64'(hit));
      if (hit) chk("fwd_data", 64'(fwd_data), 64'(fd));
      if (coal) sb[n-1][31:0] = wd;
      if (ack && n != 0) void'(sb.pop_front());
      if (we && !coal && n < DEPTH) sb.push_back({adr, wd});
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b0;
      memwrite   = 1'b0;
      dataadr    = '0;
      writedata  = '0;
      mem_ack    = 1'b0;
      lookup_adr = '0;
      #1;
      chk("rst_mem_req", 64'(mem_req), 64'(0));
      chk("rst_empty", 64'(empty), 64'(1));
      chk("rst_count", 64'(count), 64'(0));
      chk("rst_stall", 64'(stall), 64'(0));
      chk("rst_fwd_hit", 64'(fwd_hit), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // Single store, then one ack drains it.
      cycle(1'b1, 68, 16, 1'b0, 0);
      cycle(1'b0, 0, 0, 1'b0, 68);
      cycle(1'b0, 0, 0, 1'b1, 0);
      cycle(1'b0, 0, 0, 1'b0, 0);

      // Fill, stall on fifth, stall persists through a popping cycle, retry accepted.
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'(4 * i), 32'(i + 1), 1'b0, 0);
      cycle(1'b1, 16, 5, 1'b0, 0);
      cycle(1'b1, 16, 5, 1'b1, 0);
      cycle(1'b1, 16, 5, 1'b0, 0);
      repeat (4) cycle(1'b0, 0, 0, 1'b1, 0);
      cycle(1'b0, 0, 0, 1'b0, 0);

      // Coalesce into youngest; no merge into head when count==1.
      cycle(1'b1, 80, 7, 1'b0, 0);
      cycle(1'b1, 84, 9, 1'b0, 0);
      cycle(1'b1, 84, 16, 1'b0, 0);
      cycle(1'b0, 0, 0, 1'b0, 84);
      repeat (2) cycle(1'b0, 0, 0, 1'b1, 0);
      cycle(1'b1, 80, 7, 1'b0, 0);
      cycle(1'b1, 80, 5, 1'b0, 0);
      cycle(1'b0, 0, 0, 1'b0, 80);
      repeat (2) cycle(1'b0, 0, 0, 1'b1, 80);
      cycle(1'b0, 0, 0, 1'b0, 80);

      // Forwarding with a non-adjacent duplicate; popping head still forwards.
      cycle(1'b1, 68, 3, 1'b0, 0);
      cycle(1'b1, 72, 4, 1'b0, 0);
      cycle(1'b1, 68, 16, 1'b0, 0);
      cycle(1'b0, 0, 0, 1'b0, 68);
      cycle(1'b0, 0, 0, 1'b0, 76);
      cycle(1'b1, 76, 8, 1'b1, 68);
      cycle(1'b0, 0, 0, 1'b1, 72);
      repeat (2) cycle(1'b0, 0, 0, 1'b1, 76);
      cycle(1'b0, 0, 0, 1'b0, 76);

      // Continuous ack stream; pointers wrap several times.
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1, 0);
         chk("stream_count_le2", 64'(count <= CW'(2)), 64'(1));
      end
      repeat (2) cycle(1'b0, 0, 0, 1'b1, 0);
      cycle(1'b0, 0, 0, 1'b0, 0);

      // Asynchronous reset while three entries are pending.
      cycle(1'b1, 32'h200, 1, 1'b0, 0);
      cycle(1'b1, 32'h204, 2, 1'b0, 0);
      cycle(1'b1, 32'h208, 3, 1'b0, 0);
      lookup_adr = 32'h200;
      memwrite   = 1'b0;
      chk("pre_rst_mem_req", 64'(mem_req), 64'(1));
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_mem_req", 64'(mem_req), 64'(0));
      chk("mid_rst_count", 64'(count), 64'(0));
      chk("mid_rst_empty", 64'(empty), 64'(1));
      chk("mid_rst_fwd_hit", 64'(fwd_hit), 64'(0));
      sb.delete();
      #2;
      reset = 1'b1;
      @(posedge clk);
      #1;
      repeat (3) cycle(1'b0, 0, 0, 1'b1, 32'h204);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the single-cycle MIPS core's data port (memwrite/dataadr/writedata) and a slower data memory with a req/ack handshake.
- Accepts `sw` stores in one cycle and drains them in order.
- Stalls the core only when full.
- Forwards buffered data to `lw` lookups so loads see their own pending stores.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, >=2)
- AW, 32, address width (matches dataadr)
- DW, 32, data width (matches writedata)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; buffer cleared while 0
- memwrite  in  1  core store strobe
- dataadr  in  AW  core store address (ALU result), word aligned
- writedata  in  DW  core store data
- stall  out  1  core must hold current store and PC this cycle
- lookup_adr  in  AW  core load address for forwarding
- fwd_hit  out  1  lookup_adr matches a buffered entry
- fwd_data  out  DW  data of youngest matching entry
- mem_req  out  1  head entry valid and presented to memory
- mem_addr  out  AW  head address
- mem_wdata  out  DW  head data
- mem_ack  in  1  memory accepted head this cycle
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count==0 (used for fences/end of test)

Behaviour:
- Storage: circular FIFO of DEPTH {addr,data} entries, head/tail pointers wrapping modulo DEPTH, plus count register.
- Reset (reset==0, asynchronous): count=0, head=tail=0.
  - Outputs immediately: mem_req=0, empty=1, stall=0, fwd_hit=0, count=0.
  - mem_addr/mem_wdata are don't-care when mem_req=0.
  - Reset mid-drain discards all pending stores. mem_req drops without waiting for ack; the memory must tolerate an abandoned request.
- Coalesce:
  - Condition: memwrite=1, count>=2, and dataadr equals the youngest entry (tail-1) address.
  - Action: overwrite that entry's data; count and tail unchanged.
  - Permitted even when full (no stall).
  - Never coalesce into head (count==1): head is on the memory bus and must stay stable.
- Push: memwrite=1, not coalescing, count<DEPTH. Write entry at tail, tail+1.
- stall (combinational) = memwrite & (count==DEPTH) & ~coalesce.
  - Push while full is not accepted, even if mem_ack pops the same cycle.
  - The core retries next cycle.
- Pop: mem_req & mem_ack. head+1.
- Count update:
  - push&pop: unchanged
  - push only: +1
  - pop only: -1
  - coalesce with pop: -1 only if pop
- Memory handshake:
  - mem_req = (count!=0), registered-state derived.
  - mem_addr/mem_wdata = head entry; stable while mem_req=1 and mem_ack=0.
  - mem_ack while mem_req=0 is ignored.
  - Back-to-back pops allowed, one per cycle.
  - Zero-latency through path not provided: a store pushed in cycle N appears on mem_req no earlier than cycle N+1.
- Forwarding (combinational):
  - Compare lookup_adr against all valid entries (between head and tail).
  - fwd_hit=1 on any match; fwd_data = youngest matching entry.
  - The entry popping this cycle still forwards this cycle.
  - Same-cycle incoming store is not forwarded.
- Address compare uses full AW bits; no byte enables (word stores only).
- empty = (count==0); count output reflects registered value.

Test Plan:
- Reset then single store: memwrite with dataadr=68, writedata=16, mem_ack held 0.
  - Next cycle: mem_req=1, mem_addr=68, mem_wdata=16, count=1.
  - Ack one cycle: count=0, empty=1, mem_req=0.
- Fill and stall: four stores to 0,4,8,12 (data 1..4), mem_ack=0.
  - count=4.
  - Fifth store to 16: stall=1, count stays 4.
  - Assert mem_ack: pops addr 0, still stall that cycle.
  - Retry next cycle accepted: count=4, order 4,8,12,16.
- Coalesce: stores 80<-7, 84<-9, 84<-16 with no ack.
  - count=2; entry for 84 holds 16.
  - Store 80<-5 with count==1 (after acks leaving only 80): new entry pushed, not merged.
- Forwarding: buffer holds 68<-3, 72<-4, 68<-16 (non-adjacent duplicate).
  - lookup_adr=68: fwd_hit=1, fwd_data=16.
  - lookup_adr=76: fwd_hit=0.
- Simultaneous push/pop with wrap: run 10 stores with mem_ack=1 continuously.
  - count never exceeds 1-2.
  - Memory sees all 10 addresses in order; pointers wrap without loss.
- Async reset mid-drain: 3 entries pending, mem_req=1; drop reset between clock edges.
  - mem_req=0, count=0, empty=1 immediately.
  - After release no stale entries drain.
